// File: rtl/fnd_seg_capture.sv
// fnd_seg_capture: samples a multiplexed 4-digit 7-seg bus and rebuilds the value.
// FND_CAP_STATIC_EN: accept com == 4'b0000 as a static all-digit frame.
module fnd_seg_capture #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  seg,
  input  logic [3:0]  com,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic        valid,
  output logic        digit_err
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  com_q;
  logic [3:0]  mask;
  logic [15:0] shadow;
  logic [3:0]  shadow_dp;

  logic        com_onecold;
  logic        com_static;
  logic        com_legal;
  logic        com_same;
  logic [7:0]  cnt_nx;
  logic        take;
  logic [3:0]  nib;
  logic        glyph_ok;
  logic [15:0] shadow_nx;
  logic [3:0]  dp_nx;
  logic [3:0]  mask_nx;
  logic        complete;

  assign com_onecold = (com == 4'b1110) ||
                       (com == 4'b1101) ||
                       (com == 4'b1011) ||
                       (com == 4'b0111);

`ifdef FND_CAP_STATIC_EN
  assign com_static = (com == 4'b0000);
`else
  assign com_static = 1'b0;
`endif

  assign com_legal = com_onecold | com_static;
  assign com_same  = (com == com_q);

  // Settle counter: counts edges at which the current com has been seen.
  always_comb begin
    cnt_nx = 8'd1;
    if (state == SETTLE && com_same)
      cnt_nx = cnt + 8'd1;
    take = com_legal &&
           !(state == HOLD && com_same) &&
           (cnt_nx == 8'(SETTLE_CYC));
  end

  // Active-low glyph back to hex nibble.
  always_comb begin
    nib      = 4'h0;
    glyph_ok = 1'b1;
    case (seg[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  // Enabled digits (one, or all four in static mode) take the new glyph.
  always_comb begin
    shadow_nx = shadow;
    dp_nx     = shadow_dp;
    for (int i = 0; i < 4; i++) begin
      if (!com[i]) begin
        shadow_nx[4*i +: 4] = nib;
        dp_nx[i]            = ~seg[7];
      end
    end
    mask_nx  = mask | ~com;
    complete = &mask_nx;
  end

  // Settle/hold sequencing, sampling and frame assembly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      com_q     <= 4'hF;
      mask      <= 4'h0;
      shadow    <= 16'h0;
      shadow_dp <= 4'h0;
      value     <= 16'h0;
      dp        <= 4'h0;
      valid     <= 1'b0;
      digit_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      digit_err <= 1'b0;
      com_q     <= com;
      if (!com_legal) begin
        state <= IDLE;
        cnt   <= 8'd0;
      end else if (state == HOLD && com_same) begin
        state <= HOLD;
      end else if (take) begin
        state <= HOLD;
        cnt   <= cnt_nx;
        if (glyph_ok) begin
          shadow    <= shadow_nx;
          shadow_dp <= dp_nx;
          if (complete) begin
            value <= shadow_nx;
            dp    <= dp_nx;
            valid <= 1'b1;
            mask  <= 4'h0;
          end else begin
            mask <= mask_nx;
          end
        end else begin
          digit_err <= 1'b1;
        end
      end else begin
        state <= SETTLE;
        cnt   <= cnt_nx;
      end
    end
  end

endmodule

// File: tb/tb_fnd_seg_capture.sv
// tb_fnd_seg_capture: directed checks of the FND bus capture block.
// Inputs change 1ns after posedge; outputs are read 1ns after each posedge.
module tb_fnd_seg_capture;

  logic        clk;
  logic        reset_n;
  logic [7:0]  seg;
  logic [3:0]  com;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        valid;
  logic        digit_err;

  int total;
  int bad;
  int vcnt;
  int ecnt;
  int vidx;

  fnd_seg_capture #(.SETTLE_CYC(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .seg       (seg),
    .com       (com),
    .value     (value),
    .dp        (dp),
    .valid     (valid),
    .digit_err (digit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    vcnt = 0;
    ecnt = 0;
    vidx = -1;
  endtask

  task automatic drive(input logic [3:0] c,
                       input logic [7:0] s,
                       input int n);
    com = c;
    seg = s;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        vcnt++;
        vidx = i;
      end
      if (digit_err) ecnt++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    com = 4'hF;
    seg = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (value !== 16'h0) begin
      bad++;
      $display("FAIL reset_value got=%h want=0000", value);
    end
    total++;
    if (dp !== 4'h0) begin
      bad++;
      $display("FAIL reset_dp got=%b want=0000", dp);
    end
    total++;
    if ({valid, digit_err} !== 2'b00) begin
      bad++;
      $display("FAIL reset_pulses got=%b want=00", {valid, digit_err});
    end
    reset_n = 1'b1;
    drive(4'hF, 8'hFF, 2);
  endtask

  task automatic test_scan();
    clr();
    drive(4'hE, 8'hF9, 8);
    drive(4'hD, 8'hA4, 8);
    drive(4'hB, 8'hB0, 8);
    drive(4'h7, 8'h99, 8);
    total++;
    if (vcnt !== 1) begin
      bad++;
      $display("FAIL scan_valid_cnt got=%0d want=1", vcnt);
    end
    total++;
    if (vidx !== 3) begin
      bad++;
      $display("FAIL scan_latency got=%0d want=3", vidx);
    end
    total++;
    if (value !== 16'h4321 || dp !== 4'h0) begin
      bad++;
      $display("FAIL scan_value got=%h/%b want=4321/0000", value, dp);
    end
    total++;
    if (ecnt !== 0) begin
      bad++;
      $display("FAIL scan_err got=%0d want=0", ecnt);
    end
    clr();
    drive(4'hE, 8'h99, 8);
    drive(4'hD, 8'hF9, 8);
    drive(4'hB, 8'hA4, 8);
    drive(4'h7, 8'hB0, 8);
    total++;
    if (vcnt !== 1 || value !== 16'h3214) begin
      bad++;
      $display("FAIL scan_map got=%h/%0d want=3214/1", value, vcnt);
    end
    drive(4'hF, 8'hFF, 2);
  endtask

  task automatic test_glitch();
    clr();
    drive(4'hD, 8'hC0, 3);
    drive(4'hF, 8'hFF, 3);
    total++;
    if (vcnt !== 0 || ecnt !== 0) begin
      bad++;
      $display("FAIL glitch_pulse got=%0d/%0d want=0/0", vcnt, ecnt);
    end
    drive(4'hE, 8'hF9, 8);
    drive(4'hB, 8'hB0, 8);
    drive(4'h7, 8'h99, 8);
    total++;
    if (vcnt !== 0) begin
      bad++;
      $display("FAIL glitch_mask got=%0d want=0", vcnt);
    end
    drive(4'hD, 8'hA4, 4);
    drive(4'hF, 8'hFF, 4);
    total++;
    if (vcnt !== 1 || value !== 16'h4321) begin
      bad++;
      $display("FAIL settle_edge got=%h/%0d want=4321/1", value, vcnt);
    end
  endtask

  task automatic test_illegal();
    clr();
    drive(4'hE, 8'hF9, 8);
    drive(4'hD, 8'hA4, 8);
    drive(4'hB, 8'hFF, 8);
    drive(4'h7, 8'h99, 8);
    total++;
    if (ecnt !== 1) begin
      bad++;
      $display("FAIL illegal_err got=%0d want=1", ecnt);
    end
    total++;
    if (vcnt !== 0) begin
      bad++;
      $display("FAIL illegal_novalid got=%0d want=0", vcnt);
    end
    drive(4'hB, 8'h88, 8);
    drive(4'hF, 8'hFF, 2);
    total++;
    if (vcnt !== 1 || value !== 16'h4A21) begin
      bad++;
      $display("FAIL illegal_resend got=%h/%0d want=4A21/1", value, vcnt);
    end
  endtask

  task automatic test_dp_overwrite();
    clr();
    drive(4'hD, 8'h40, 8);
    drive(4'hF, 8'hFF, 2);
    drive(4'hD, 8'h79, 8);
    drive(4'hE, 8'hF9, 8);
    drive(4'hB, 8'hB0, 8);
    drive(4'h7, 8'h99, 8);
    drive(4'hF, 8'hFF, 2);
    total++;
    if (vcnt !== 1 || value !== 16'h4311) begin
      bad++;
      $display("FAIL overwrite got=%h/%0d want=4311/1", value, vcnt);
    end
    total++;
    if (dp !== 4'b0010) begin
      bad++;
      $display("FAIL dp got=%b want=0010", dp);
    end
  endtask

  task automatic test_reset_mid();
    clr();
    drive(4'hE, 8'hF9, 8);
    drive(4'hD, 8'hA4, 8);
    com = 4'hF;
    seg = 8'hFF;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    total++;
    if (value !== 16'h0 || dp !== 4'h0 ||
        valid !== 1'b0 || digit_err !== 1'b0) begin
      bad++;
      $display("FAIL midreset got=%h/%b/%b%b want=0000/0000/00",
               value, dp, valid, digit_err);
    end
    drive(4'hB, 8'hB0, 8);
    drive(4'h7, 8'h99, 8);
    total++;
    if (vcnt !== 0) begin
      bad++;
      $display("FAIL midreset_partial got=%0d want=0", vcnt);
    end
    drive(4'hE, 8'hF9, 8);
    drive(4'hD, 8'hA4, 8);
    drive(4'hF, 8'hFF, 2);
    total++;
    if (vcnt !== 1 || value !== 16'h4321) begin
      bad++;
      $display("FAIL midreset_refill got=%h/%0d want=4321/1", value, vcnt);
    end
  endtask

  task automatic test_static();
    clr();
    drive(4'h0, 8'h92, 10);
    drive(4'hF, 8'hFF, 2);
`ifdef FND_CAP_STATIC_EN
    total++;
    if (vcnt !== 1 || value !== 16'h5555 || dp !== 4'h0) begin
      bad++;
      $display("FAIL static got=%h/%b/%0d want=5555/0000/1",
               value, dp, vcnt);
    end
`else
    total++;
    if (vcnt !== 0 || ecnt !== 0 || value !== 16'h4321) begin
      bad++;
      $display("FAIL static_off got=%h/%0d/%0d want=4321/0/0",
               value, vcnt, ecnt);
    end
`endif
  endtask

  initial begin
    total = 0;
    bad = 0;
    clr();
    reset_n = 1'b0;
    com = 4'hF;
    seg = 8'hFF;
    test_reset();
    test_scan();
    test_glitch();
    test_illegal();
    test_dp_overwrite();
    test_reset_mid();
    test_static();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
